data_deskew: RTL

Realigns the diagonally skewed output wavefront of the systolic GEMV/GEMM array into whole rows. It is the output-side counterpart of the input skew stage, which delays lane i by i+1 cycles. Lane i is delayed here by (LANES-1-i) cycles and then registered, so every element of one row leaves on the same cycle. The block sits between the array's bottom/right edge and the result writeback path. It adds an aligned valid, a skew-violation flag and a row counter.

---
 rtl/data_deskew_pkg.sv | 26 ++
 rtl/data_deskew_lane_delay.sv | 50 +++++
 rtl/data_deskew.sv | 96 +++++++++
 3 files changed

// File: rtl/data_deskew_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_deskew_pkg
// Description : Constants and helpers shared by the output deskew stage and
//               the input skew stage. Both ends of the systolic array import
//               the same defaults so the lane count and element width cannot
//               drift apart.
//                 c_default_data_width : width of one lane element
//                 c_default_lanes      : lanes per array tile column
//                 c_max_lanes          : upper limit on supported lanes
//                 lane_lsb()           : bit offset of a lane in a packed vector
// Revision    : 1.0 - initial release
// ============================================================================
package data_deskew_pkg;

    localparam int c_default_data_width = 22;
    localparam int c_default_lanes      = 6;
    localparam int c_max_lanes          = 16;

    // Lane k of a packed vector occupies [width*(k+1)-1 : width*k].
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage : data_deskew_pkg
`default_nettype wire

// File: rtl/data_deskew_lane_delay.sv
`default_nettype none
// ============================================================================
// Module      : lane_delay
// Description : Fixed-depth shift register for one lane (data and valid
//               travel together). DEPTH=0 is a pure pass-through.
//               Ports:
//                 clk : clock, rising edge
//                 rst : asynchronous active-high reset, clears every stage
//                 en  : advance; when 0 every stage holds
//                 d   : lane input  [WIDTH-1:0]
//                 q   : lane output [WIDTH-1:0], d delayed by DEPTH advances
// Revision    : 1.0 - initial release
// ============================================================================
module lane_delay #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_pass
        // The last lane needs no delay; the control inputs are unused here.
        logic w_unused;
        assign w_unused = &{1'b0, clk, rst, en};
        assign q        = d;
    end else begin : g_shift
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) begin
                    r_stage[k] <= '0;
                end
            end else if (en) begin
                r_stage[0] <= d;
                for (int k = 1; k < DEPTH; k++) begin
                    r_stage[k] <= r_stage[k-1];
                end
            end
        end

        assign q = r_stage[DEPTH-1];
    end

endmodule : lane_delay
`default_nettype wire

// File: rtl/data_deskew.sv
`default_nettype none
// ============================================================================
// Module      : data_deskew
// Description : Realigns the diagonally skewed output wavefront of the
//               systolic array into whole rows. Lane i is delayed by
//               LANES-1-i advances so all lanes of one row meet at the tap,
//               then the row is registered when every lane is valid.
//               Ports:
//                 clk        : clock, rising edge
//                 rst        : asynchronous active-high reset
//                 en         : global advance; when 0 everything holds
//                 din        : skewed lane data, DATA_WIDTH*LANES packed
//                 din_valid  : per-lane valid, skewed like din
//                 dout       : aligned row, same packing as din
//                 dout_valid : dout carries a complete row
//                 skew_err   : lane valids disagreed on last advance
//                 row_count  : rows emitted since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module data_deskew
    import data_deskew_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int LANES      = c_default_lanes,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic                        en,
    input  wire logic [DATA_WIDTH*LANES-1:0] din,
    input  wire logic [LANES-1:0]            din_valid,
    output logic      [DATA_WIDTH*LANES-1:0] dout,
    output logic                             dout_valid,
    output logic                             skew_err,
    output logic      [CNT_WIDTH-1:0]        row_count
);

    logic [DATA_WIDTH*LANES-1:0] w_tap_data;
    logic [LANES-1:0]            w_tap_valid;
    logic                        w_all_v;
    logic                        w_any_v;

    logic [DATA_WIDTH*LANES-1:0] r_dout;
    logic                        r_dout_valid;
    logic                        r_skew_err;
    logic [CNT_WIDTH-1:0]        r_row_count;

    // Lane i arrives i advances after lane 0, so it waits LANES-1-i more.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_WIDTH:0] w_lane_in;
        logic [DATA_WIDTH:0] w_lane_out;

        assign w_lane_in = {din_valid[i], din[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]};

        lane_delay #(
            .WIDTH (DATA_WIDTH + 1),
            .DEPTH (LANES - 1 - i)
        ) u_lane_delay (
            .clk (clk),
            .rst (rst),
            .en  (en),
            .d   (w_lane_in),
            .q   (w_lane_out)
        );

        assign w_tap_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = w_lane_out[DATA_WIDTH-1:0];
        assign w_tap_valid[i]                                    = w_lane_out[DATA_WIDTH];
    end

    assign w_all_v = &w_tap_valid;
    assign w_any_v = |w_tap_valid;

    // A partially valid tap is a broken row: flag it, never load or count it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_skew_err   <= 1'b0;
            r_row_count  <= '0;
        end else if (en) begin
            r_dout_valid <= w_all_v;
            r_skew_err   <= w_any_v & ~w_all_v;
            if (w_all_v) begin
                r_dout      <= w_tap_data;
                r_row_count <= r_row_count + CNT_WIDTH'(1);
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign skew_err   = r_skew_err;
    assign row_count  = r_row_count;

endmodule : data_deskew
`default_nettype wire
